// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - initiator/responder bus bundle for the data memory responder
interface data_mem_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Ready;
   logic        Error;
   logic        Busy;

   modport master (
      output MemRead, MemWrite, Address, WriteData,
      input  ReadData, Ready, Error, Busy
   );

   modport slave (
      input  MemRead, MemWrite, Address, WriteData,
      output ReadData, Ready, Error, Busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with fixed wait states and a one-cycle response strobe
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   data_mem_responder_if.slave  bus
);

   localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH30   = 30'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

   stateT             state;
   stateT             nextState;
   logic [3:0]        waitCnt;
   logic [IDX_W-1:0]  capIdx;
   logic [31:0]       capData;
   logic              capRead;
   logic              capWrite;
   logic              capErr;
   logic [31:0]       readDataReg;
   logic [31:0]       mem [DEPTH_WORDS];

   logic reqSeen;
   logic acceptReq;
   logic reqErr;
   logic respEntry;

   // A new request can be taken in IDLE or on the edge that closes RESP.
   assign reqSeen   = bus.MemRead | bus.MemWrite;
   assign acceptReq = reqSeen && ((state == IDLE) || (state == RESP));
   assign reqErr    = (bus.Address[1:0] != 2'b00) ||
                      (bus.Address[31:2] >= DEPTH30) ||
                      (bus.MemRead && bus.MemWrite);
   assign respEntry = (state == WAIT) && (waitCnt == 4'd0);

   // State register; reset wins over any pending transition.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode: count down in WAIT, single-cycle RESP.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (reqSeen) nextState = WAIT;
         WAIT:    if (waitCnt == 4'd0) nextState = RESP;
         RESP:    nextState = reqSeen ? WAIT : IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Output decode: strobe and error only exist while in RESP.
   always_comb begin
      bus.Ready    = (state == RESP);
      bus.Error    = (state == RESP) && capErr;
      bus.Busy     = (state != IDLE);
      bus.ReadData = readDataReg;
   end

   // Request capture, wait counter and registered read data.
   always_ff @(posedge CLK) begin
      if (RST) begin
         waitCnt     <= 4'd0;
         capIdx      <= '0;
         capData     <= 32'd0;
         capRead     <= 1'b0;
         capWrite    <= 1'b0;
         capErr      <= 1'b0;
         readDataReg <= 32'd0;
      end else begin
         if (acceptReq) begin
            waitCnt  <= WAIT_LOAD;
            capIdx   <= bus.Address[IDX_W+1:2];
            capData  <= bus.WriteData;
            capRead  <= bus.MemRead;
            capWrite <= bus.MemWrite;
            capErr   <= reqErr;
         end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
            waitCnt <= waitCnt - 4'd1;
         end
         if (respEntry) begin
            if (capErr) begin
               readDataReg <= 32'd0;
            end else if (capRead) begin
               readDataReg <= mem[capIdx];
            end
         end
      end
   end

   // Storage array is never cleared; a write lands on the RESP-entry edge unless reset aborts it.
   always_ff @(posedge CLK) begin
      if (!RST && respEntry && capWrite && !capErr) begin
         mem[capIdx] <= capData;
      end
   end

endmodule
